// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/PC unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam int XLEN_DEFAULT  = 32;
  localparam int PC_INC        = 4;
  localparam int J_TARGET_BITS = 26;

endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Combinational next-PC selection: jr > jump > branch > sequential.
// With FETCH_MISALIGN_TRAP_EN a misaligned jr target redirects to TRAP_VECTOR.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0080)
`endif
) (
  input  logic [XLEN-1:0]          pc_plus4,
  input  logic [J_TARGET_BITS-1:0] instr_index,
  input  logic [15:0]              branch_imm,
  input  logic                     branch_taken,
  input  logic                     jump,
  input  logic                     jr,
  input  logic [XLEN-1:0]          jr_target,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                     misalign,
`endif
  output logic [XLEN-1:0]          next_pc
);

  logic [XLEN-1:0] jr_word_s;
  logic [XLEN-1:0] jump_tgt_s;
  logic [XLEN-1:0] branch_off_s;
  logic [XLEN-1:0] branch_tgt_s;

  // Low two bits of the register target are forced to zero (word aligned).
  assign jr_word_s    = jr_target & {{(XLEN-2){1'b1}}, 2'b00};
  assign jump_tgt_s   = {pc_plus4[XLEN-1:J_TARGET_BITS+2], instr_index, 2'b00};
  assign branch_off_s = {{(XLEN-18){branch_imm[15]}}, branch_imm, 2'b00};
  assign branch_tgt_s = pc_plus4 + branch_off_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = jr & (jr_target[1:0] != 2'b00);
`endif

  // Priority redirect mux.
  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign) begin
        next_pc = TRAP_VECTOR;
      end else begin
        next_pc = jr_word_s;
      end
`else
      next_pc = jr_word_s;
`endif
    end else if (jump) begin
      next_pc = jump_tgt_s;
    end else if (branch_taken) begin
      next_pc = branch_tgt_s;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch unit.
// Optional misaligned-jr trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
`ifdef FETCH_MISALIGN_TRAP_EN
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0080),
`endif
  parameter int              MAX_WAIT     = 15
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            branch_taken,
  input  logic [15:0]     branch_imm,
  input  logic            jump,
  input  logic            jal,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_target,
  output logic [XLEN-1:0] ra_out,
  output logic            timeout_err,
  output logic            misalign_err
);

  localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  fetch_state_t     state_r;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  ra_r;
  logic [31:0]      instr_r;
  logic             instr_valid_r;
  logic             imem_req_r;
  logic             timeout_err_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [XLEN-1:0]  pc_plus4_s;
  logic [XLEN-1:0]  next_pc_s;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic             misalign_s;
  logic             misalign_err_r;
`endif

  assign pc_plus4_s = pc_r + XLEN'(PC_INC);

  next_pc_sel #(
    .XLEN        (XLEN)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .TRAP_VECTOR (TRAP_VECTOR)
`endif
  ) u_next_pc_sel (
    .pc_plus4     (pc_plus4_s),
    .instr_index  (instr_r[J_TARGET_BITS-1:0]),
    .branch_imm   (branch_imm),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jr           (jr),
    .jr_target    (jr_target),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign     (misalign_s),
`endif
    .next_pc      (next_pc_s)
  );

  // Fetch FSM with wait counter and all architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      pc_r           <= RESET_VECTOR;
      ra_r           <= {XLEN{1'b0}};
      instr_r        <= 32'h0000_0000;
      instr_valid_r  <= 1'b0;
      imem_req_r     <= 1'b0;
      timeout_err_r  <= 1'b0;
      wait_cnt_r     <= {CNT_W{1'b0}};
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_err_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_r    <= FETCH;
          imem_req_r <= 1'b1;
        end
        FETCH: begin
          state_r    <= WAIT;
          imem_req_r <= 1'b0;
          wait_cnt_r <= {CNT_W{1'b0}};
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr_r       <= imem_rdata;
            instr_valid_r <= 1'b1;
            wait_cnt_r    <= {CNT_W{1'b0}};
            state_r       <= HOLD;
          end else begin
            // Timeout is only flagged; the unit keeps waiting without re-requesting.
            if (wait_cnt_r != MAX_CNT) begin
              wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end
            if (wait_cnt_r >= LAST_CNT) begin
              timeout_err_r <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid_r <= 1'b0;
            pc_r          <= next_pc_s;
            imem_req_r    <= 1'b1;
            state_r       <= FETCH;
            if (jal) begin
              ra_r <= pc_plus4_s;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misalign_s) begin
              misalign_err_r <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state_r       <= IDLE;
          imem_req_r    <= 1'b0;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign instr_valid = instr_valid_r;
  assign instr       = instr_r;
  assign pc_out      = pc_r;
  assign pc_plus4    = pc_plus4_s;
  assign ra_out      = ra_r;
  assign timeout_err = timeout_err_r;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_err = misalign_err_r;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: redirect vector table plus stall, timeout and reset sequences.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_imm = 16'h0;
  logic        jump = 1'b0;
  logic        jal = 1'b0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] ra_out;
  logic        timeout_err;
  logic        misalign_err;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .MAX_WAIT     (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jal          (jal),
    .jr           (jr),
    .jr_target    (jr_target),
    .ra_out       (ra_out),
    .timeout_err  (timeout_err),
    .misalign_err (misalign_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        br;
    logic [15:0] imm;
    logic        jmp;
    logic        lnk;
    logic        jrr;
    logic [31:0] jtgt;
    logic [31:0] exp_next;
    logic [31:0] exp_ra;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_addr_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic vec_t mk(input logic [31:0] rdata, input logic br, input logic [15:0] imm,
                              input logic jmp, input logic lnk, input logic jrr,
                              input logic [31:0] jtgt, input logic [31:0] exp_next,
                              input logic [31:0] exp_ra);
    vec_t v;
    v.rdata = rdata; v.br = br; v.imm = imm; v.jmp = jmp; v.lnk = lnk;
    v.jrr = jrr; v.jtgt = jtgt; v.exp_next = exp_next; v.exp_ra = exp_ra;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    branch_taken = 1'b0; branch_imm = 16'h0; jump = 1'b0; jal = 1'b0; jr = 1'b0; jr_target = 32'h0;
  endtask

  // Wait (bounded) for a request pulse and compare its address with the scoreboard head.
  task automatic wait_req(output int waited, output logic [31:0] addr);
    logic [31:0] exp;
    waited = 0;
    while (imem_req !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    exp = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
    check("imem_addr", imem_addr, exp);
    addr = exp;
  endtask

  logic [31:0] trap_base;
  logic [31:0] cur;
  logic [31:0] held_ra;
  int          w;
  logic        saw_req;

  initial begin
    trap_base = TRAP_ON ? 32'h0000_0080 : 32'h0000_0100;
    vecs.push_back(mk(32'h2000_0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 32'h0));
    vecs.push_back(mk(32'h2000_0002, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 32'h0));
    vecs.push_back(mk(32'h2000_0003, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_000C, 32'h0));
    vecs.push_back(mk(32'h2000_0004, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0010, 32'h0));
    vecs.push_back(mk(32'h1000_FFFC, 1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 32'h0));
    vecs.push_back(mk(32'h2000_0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0008, 32'h0));
    vecs.push_back(mk(32'h2000_0006, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_000C, 32'h0));
    vecs.push_back(mk(32'h2000_0007, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0010, 32'h0));
    vecs.push_back(mk(32'h1000_0003, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0020, 32'h0));
    vecs.push_back(mk(32'h0000_0008, 1'b1, 16'h0007, 1'b1, 1'b0, 1'b1, 32'h3000_0000, 32'h3000_0000, 32'h0));
    vecs.push_back(mk(32'h0C00_0040, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h0, 32'h3000_0100, 32'h3000_0004));
    vecs.push_back(mk(32'h0C00_0040, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0400, 32'h3000_0104));
    vecs.push_back(mk(32'h0800_0010, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0040, 32'h3000_0104));
    vecs.push_back(mk(32'h0000_0008, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 32'h0000_0102, trap_base, 32'h3000_0104));
    vecs.push_back(mk(32'h0000_0008, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, trap_base + 32'd4));
    vecs.push_back(mk(32'h2000_0008, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, trap_base + 32'd4));
    vecs.push_back(mk(32'h1000_8000, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFE_0004, trap_base + 32'd4));

    // Reset state.
    repeat (3) step();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_ra", ra_out, 32'h0);
    check("rst_timeout", {31'b0, timeout_err}, 32'd0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);
    reset = 1'b0;
    exp_addr_q.push_back(32'h0000_0000);

    // Table-driven fetch/accept with redirects.
    for (int i = 0; i < vecs.size(); i++) begin
      wait_req(w, cur);
      check("req_spacing", w, (i == 0) ? 32'd1 : 32'd0);
      jal = 1'b1; jr = 1'b1; jump = 1'b1; jr_target = $urandom;
      step();
      check("req_pulse", {31'b0, imem_req}, 32'd0);
      clear_redirects();
      imem_rvalid = 1'b1;
      imem_rdata  = vecs[i].rdata;
      step();
      imem_rvalid = 1'b0;
      check("instr_valid", {31'b0, instr_valid}, 32'd1);
      check("instr", instr, vecs[i].rdata);
      check("pc_out", pc_out, cur);
      check("pc_plus4", pc_plus4, cur + 32'd4);
      instr_ready  = 1'b1;
      branch_taken = vecs[i].br;
      branch_imm   = vecs[i].imm;
      jump         = vecs[i].jmp;
      jal          = vecs[i].lnk;
      jr           = vecs[i].jrr;
      jr_target    = vecs[i].jtgt;
      exp_addr_q.push_back(vecs[i].exp_next);
      step();
      instr_ready = 1'b0;
      clear_redirects();
      check("valid_clr", {31'b0, instr_valid}, 32'd0);
      check("ra_out", ra_out, vecs[i].exp_ra);
      check("misalign_err", {31'b0, misalign_err}, (TRAP_ON && i >= 13) ? 32'd1 : 32'd0);
    end
    held_ra = trap_base + 32'd4;

    // Stall in HOLD with spurious responses.
    wait_req(w, cur);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    saw_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      imem_rvalid = (k % 2 == 0);
      imem_rdata  = $urandom;
      jal = 1'b1; jr = 1'b1; jr_target = $urandom;
      step();
      if (imem_req === 1'b1) saw_req = 1'b1;
      check("stall_instr", instr, 32'h1234_5678);
      check("stall_pc", pc_out, cur);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    imem_rvalid = 1'b0;
    clear_redirects();
    check("stall_no_req", {31'b0, saw_req}, 32'd0);
    check("stall_ra", ra_out, held_ra);
    instr_ready = 1'b1;
    exp_addr_q.push_back(cur + 32'd4);
    step();
    instr_ready = 1'b0;

    // Timeout: no response for MAX_WAIT cycles.
    wait_req(w, cur);
    step();
    saw_req = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (imem_req === 1'b1) saw_req = 1'b1;
    end
    check("timeout_early", {31'b0, timeout_err}, 32'd0);
    step();
    check("timeout_set", {31'b0, timeout_err}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      if (imem_req === 1'b1) saw_req = 1'b1;
    end
    check("timeout_sticky", {31'b0, timeout_err}, 32'd1);
    check("timeout_no_req", {31'b0, saw_req}, 32'd0);
    check("timeout_valid", {31'b0, instr_valid}, 32'd0);

    // Reset during WAIT, then responses during IDLE/FETCH are dropped.
    reset = 1'b1;
    step();
    check("rst2_pc", pc_out, 32'h0);
    check("rst2_timeout", {31'b0, timeout_err}, 32'd0);
    check("rst2_ra", ra_out, 32'h0);
    check("rst2_valid", {31'b0, instr_valid}, 32'd0);
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    exp_addr_q.push_back(32'h0000_0000);
    wait_req(w, cur);
    check("rst2_req_spacing", w, 32'd1);
    check("idle_drop", {31'b0, instr_valid}, 32'd0);
    step();
    check("fetch_drop", {31'b0, instr_valid}, 32'd0);
    imem_rdata = 32'hCAFE_F00D;
    step();
    imem_rvalid = 1'b0;
    check("rst2_instr", instr, 32'hCAFE_F00D);
    check("rst2_valid_set", {31'b0, instr_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
